// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data load/store (D).
// One requester is served at a time; the memory request is held until mem_ready or a
// timeout. Misaligned requests are answered with an error ack without touching memory.

module mem_port_arbiter #(
   parameter int unsigned TIMEOUT  = 255,  // 0 disables the timeout
   parameter int unsigned DATA_RUN = 4     // max back-to-back D grants while IF waits, >= 1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   // instruction fetch side
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic [31:0] o_if_rdata,
   output logic        o_if_ack,
   output logic        o_if_err,
   // data load/store side
   input  logic        i_d_req,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wdata,
   input  logic        i_d_r_w,
   input  logic [1:0]  i_d_size,
   input  logic        i_d_unsigned,
   output logic [31:0] o_d_rdata,
   output logic        o_d_ack,
   output logic        o_d_err,
   // memory side
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_mem_r_w,
   output logic [1:0]  o_mem_size,
   output logic        o_mem_unsigned,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ready
);

   localparam int unsigned TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned RCW = (DATA_RUN > 1) ? $clog2(DATA_RUN + 1) : 1;
   localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT - 1);
   localparam logic [RCW-1:0] RC_MAX  = RCW'(DATA_RUN);
   localparam bit             TO_EN   = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      StIdle,
      StIfBusy,
      StDBusy
   } state_e;

   state_e           r_state;
   logic [RCW-1:0]   r_run_cnt;
   logic [TCW-1:0]   r_tcnt;

   logic             w_if_pend;
   logic             w_d_pend;
   logic             w_run_full;
   logic             w_gnt_d;
   logic             w_gnt_if;
   logic             w_if_mis;
   logic             w_d_mis;
   logic             w_timeout;
   logic             w_fin;
   logic             w_fin_err;
   logic [31:0]      w_fin_data;

   // A requester being acked this cycle still has its req high; it must not be re-granted.
   assign w_if_pend  = i_if_req & ~o_if_ack;
   assign w_d_pend   = i_d_req & ~o_d_ack;

   // D has priority unless it has used up its run while IF was waiting.
   assign w_run_full = (r_run_cnt == RC_MAX);
   assign w_gnt_d    = w_d_pend & ~(w_if_pend & w_run_full);
   assign w_gnt_if   = w_if_pend & ~w_gnt_d;

   assign w_if_mis   = |i_if_addr[1:0];
   assign w_d_mis    = (i_d_size == 2'd3)
                     | ((i_d_size == 2'd1) & i_d_addr[0])
                     | ((i_d_size == 2'd2) & (|i_d_addr[1:0]));

   // Timeout fires on the edge that would complete TIMEOUT waiting cycles.
   assign w_timeout  = TO_EN && (r_tcnt == TC_LAST);

   // mem_ready takes precedence over a coincident timeout.
   assign w_fin      = i_mem_ready | w_timeout;
   assign w_fin_err  = ~i_mem_ready;
   assign w_fin_data = (i_mem_ready && o_mem_r_w) ? i_mem_rdata : 32'd0;

   // Arbitration FSM with registered memory request fields and ack/err pulses.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state        <= StIdle;
         r_run_cnt      <= '0;
         r_tcnt         <= '0;
         o_if_rdata     <= 32'd0;
         o_if_ack       <= 1'b0;
         o_if_err       <= 1'b0;
         o_d_rdata      <= 32'd0;
         o_d_ack        <= 1'b0;
         o_d_err        <= 1'b0;
         o_mem_req      <= 1'b0;
         o_mem_addr     <= 32'd0;
         o_mem_wdata    <= 32'd0;
         o_mem_r_w      <= 1'b1;
         o_mem_size     <= 2'd0;
         o_mem_unsigned <= 1'b0;
      end else begin
         o_if_ack <= 1'b0;
         o_if_err <= 1'b0;
         o_d_ack  <= 1'b0;
         o_d_err  <= 1'b0;

         unique case (r_state)
            StIdle: begin
               if (w_gnt_d) begin
                  if (w_if_pend && !w_run_full) begin
                     r_run_cnt <= r_run_cnt + 1'b1;
                  end
                  if (w_d_mis) begin
                     o_d_ack   <= 1'b1;
                     o_d_err   <= 1'b1;
                     o_d_rdata <= 32'd0;
                  end else begin
                     o_mem_req      <= 1'b1;
                     o_mem_addr     <= i_d_addr;
                     o_mem_wdata    <= i_d_wdata;
                     o_mem_r_w      <= i_d_r_w;
                     o_mem_size     <= i_d_size;
                     o_mem_unsigned <= i_d_unsigned;
                     r_tcnt         <= '0;
                     r_state        <= StDBusy;
                  end
               end else if (w_gnt_if) begin
                  r_run_cnt <= '0;
                  if (w_if_mis) begin
                     o_if_ack   <= 1'b1;
                     o_if_err   <= 1'b1;
                     o_if_rdata <= 32'd0;
                  end else begin
                     o_mem_req      <= 1'b1;
                     o_mem_addr     <= i_if_addr;
                     o_mem_wdata    <= 32'd0;
                     o_mem_r_w      <= 1'b1;
                     o_mem_size     <= 2'd2;
                     o_mem_unsigned <= 1'b0;
                     r_tcnt         <= '0;
                     r_state        <= StIfBusy;
                  end
               end
            end

            StIfBusy, StDBusy: begin
               if (w_fin) begin
                  o_mem_req <= 1'b0;
                  r_state   <= StIdle;
                  if (r_state == StIfBusy) begin
                     o_if_ack   <= 1'b1;
                     o_if_err   <= w_fin_err;
                     o_if_rdata <= w_fin_data;
                  end else begin
                     o_d_ack    <= 1'b1;
                     o_d_err    <= w_fin_err;
                     o_d_rdata  <= w_fin_data;
                  end
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end

            default: begin
               o_mem_req <= 1'b0;
               r_state   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a transaction-level reference model.

module tb_mem_port_arbiter;

   localparam int TO = 8;
   localparam int DR = 4;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic [31:0] o_if_rdata;
   logic        o_if_ack;
   logic        o_if_err;
   logic        i_d_req;
   logic [31:0] i_d_addr;
   logic [31:0] i_d_wdata;
   logic        i_d_r_w;
   logic [1:0]  i_d_size;
   logic        i_d_unsigned;
   logic [31:0] o_d_rdata;
   logic        o_d_ack;
   logic        o_d_err;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        o_mem_r_w;
   logic [1:0]  o_mem_size;
   logic        o_mem_unsigned;
   logic [31:0] i_mem_rdata;
   logic        i_mem_ready;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .TIMEOUT  (TO),
      .DATA_RUN (DR)
   ) u_dut (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_if_req       (i_if_req),
      .i_if_addr      (i_if_addr),
      .o_if_rdata     (o_if_rdata),
      .o_if_ack       (o_if_ack),
      .o_if_err       (o_if_err),
      .i_d_req        (i_d_req),
      .i_d_addr       (i_d_addr),
      .i_d_wdata      (i_d_wdata),
      .i_d_r_w        (i_d_r_w),
      .i_d_size       (i_d_size),
      .i_d_unsigned   (i_d_unsigned),
      .o_d_rdata      (o_d_rdata),
      .o_d_ack        (o_d_ack),
      .o_d_err        (o_d_err),
      .o_mem_req      (o_mem_req),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wdata    (o_mem_wdata),
      .o_mem_r_w      (o_mem_r_w),
      .o_mem_size     (o_mem_size),
      .o_mem_unsigned (o_mem_unsigned),
      .i_mem_rdata    (i_mem_rdata),
      .i_mem_ready    (i_mem_ready)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   int          m_side = 0;   // 0 none, 1 fetch in memory, 2 data in memory
   int          m_wait = 0;   // memory cycles spent without mem_ready
   int          m_run  = 0;   // D grants while IF waited
   logic        e_if_ack = 0, e_if_err = 0, e_d_ack = 0, e_d_err = 0, e_mem_req = 0;
   logic [31:0] e_if_rdata = 0, e_d_rdata = 0, e_mem_addr = 0, e_mem_wdata = 0;
   logic        e_mem_rw = 1, e_mem_uns = 0;
   logic [1:0]  e_mem_size = 0;

   function automatic bit misaligned(input int size, input logic [31:0] addr);
      if (size == 3) return 1'b1;
      return (addr % (32'd1 << size)) != 0;
   endfunction

   task automatic model_step();
      bit          if_pend, d_pend, pick_d, err;
      logic [31:0] data;
      if (i_reset) begin
         m_side = 0; m_wait = 0; m_run = 0;
         e_if_ack = 0; e_if_err = 0; e_d_ack = 0; e_d_err = 0; e_mem_req = 0;
         e_mem_rw = 1;
         return;
      end
      if_pend = i_if_req && !e_if_ack;
      d_pend  = i_d_req && !e_d_ack;
      e_if_ack = 0; e_if_err = 0; e_d_ack = 0; e_d_err = 0;
      if (m_side == 0) begin
         pick_d = d_pend && !(if_pend && m_run == DR);
         if (pick_d) begin
            if (if_pend && m_run < DR) m_run++;
            if (misaligned(int'(i_d_size), i_d_addr)) begin
               e_d_ack = 1; e_d_err = 1; e_d_rdata = 0;
            end else begin
               m_side = 2; m_wait = 0; e_mem_req = 1;
               e_mem_addr = i_d_addr; e_mem_wdata = i_d_wdata; e_mem_rw = i_d_r_w;
               e_mem_size = i_d_size; e_mem_uns = i_d_unsigned;
            end
         end else if (if_pend) begin
            m_run = 0;
            if (i_if_addr % 4 != 0) begin
               e_if_ack = 1; e_if_err = 1; e_if_rdata = 0;
            end else begin
               m_side = 1; m_wait = 0; e_mem_req = 1;
               e_mem_addr = i_if_addr; e_mem_wdata = 0; e_mem_rw = 1;
               e_mem_size = 2; e_mem_uns = 0;
            end
         end
      end else begin
         err = 0;
         if (!i_mem_ready) begin
            m_wait++;
            err = (TO != 0 && m_wait == TO);
         end
         if (i_mem_ready || err) begin
            data = (!err && e_mem_rw) ? i_mem_rdata : 32'd0;
            if (m_side == 1) begin
               e_if_ack = 1; e_if_err = err; e_if_rdata = data;
            end else begin
               e_d_ack = 1; e_d_err = err; e_d_rdata = data;
            end
            m_side = 0; e_mem_req = 0;
         end
      end
   endtask

   task automatic compare_all();
      check_val("mem_req", o_mem_req, e_mem_req);
      check_val("if_ack", o_if_ack, e_if_ack);
      check_val("d_ack", o_d_ack, e_d_ack);
      check_val("ack_excl", o_if_ack & o_d_ack, 0);
      if (e_if_ack) begin
         check_val("if_err", o_if_err, e_if_err);
         check_val("if_rdata", o_if_rdata, e_if_rdata);
      end
      if (e_d_ack) begin
         check_val("d_err", o_d_err, e_d_err);
         check_val("d_rdata", o_d_rdata, e_d_rdata);
      end
      if (e_mem_req) begin
         check_val("mem_addr", o_mem_addr, e_mem_addr);
         check_val("mem_wdata", o_mem_wdata, e_mem_wdata);
         check_val("mem_r_w", o_mem_r_w, e_mem_rw);
         check_val("mem_size", o_mem_size, e_mem_size);
         check_val("mem_unsigned", o_mem_unsigned, e_mem_uns);
      end
   endtask

   // One clock: model follows the DUT edge, outputs checked 1 time unit later,
   // returns at the falling edge where new inputs are applied.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      i_if_req = 0; i_d_req = 0; i_mem_ready = 0;
   endtask

   task automatic new_if();
      i_if_req  = 1;
      i_if_addr = 32'h1000 + 4 * ($urandom % 64);
      if ($urandom % 8 == 0) i_if_addr = i_if_addr + ($urandom % 3) + 1;
   endtask

   task automatic new_d();
      int r;
      r = $urandom % 16;
      i_d_req      = 1;
      i_d_size     = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      i_d_addr     = 32'h8000 | ($urandom % 256);
      if ($urandom % 4 != 0) i_d_addr = i_d_addr & ~32'h3;
      i_d_wdata    = $urandom;
      i_d_r_w      = $urandom % 2;
      i_d_unsigned = $urandom % 2;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  n, dcount, first_if, mem_cnt, mem_dly;
      bit  if_seen, prev_req, armed;

      i_reset = 1; idle_inputs();
      i_if_addr = 0; i_d_addr = 0; i_d_wdata = 0; i_d_r_w = 1; i_d_size = 0;
      i_d_unsigned = 0; i_mem_rdata = 0;
      repeat (3) tick();
      check_val("rst_mem_req", o_mem_req, 0);
      check_val("rst_mem_r_w", o_mem_r_w, 1);
      check_val("rst_mem_addr", o_mem_addr, 0);
      check_val("rst_if_ack", o_if_ack, 0);
      check_val("rst_d_ack", o_d_ack, 0);
      check_val("rst_if_rdata", o_if_rdata, 0);
      i_reset = 0;
      tick();

      // fetch 0x100, memory answers in its first cycle
      i_if_req = 1; i_if_addr = 32'h100;
      tick();
      check_val("t1_mem_req", o_mem_req, 1);
      check_val("t1_early_ack", o_if_ack, 0);
      i_mem_ready = 1; i_mem_rdata = 32'h00500093;
      tick();
      check_val("t1_ack", o_if_ack, 1);
      check_val("t1_rdata", o_if_rdata, 32'h00500093);
      check_val("t1_err", o_if_err, 0);
      idle_inputs();
      tick();

      // simultaneous D load and IF: D first, IF granted right after d_ack
      i_if_req = 1; i_if_addr = 32'h104;
      i_d_req = 1; i_d_addr = 32'h2000; i_d_r_w = 1; i_d_size = 2; i_d_unsigned = 0;
      tick();
      check_val("t2_d_first", o_mem_addr, 32'h2000);
      i_mem_ready = 1; i_mem_rdata = 32'h11223344;
      tick();
      check_val("t2_d_ack", o_d_ack, 1);
      check_val("t2_no_if_ack", o_if_ack, 0);
      i_d_req = 0; i_mem_ready = 0;
      tick();
      check_val("t2_if_gnt", o_mem_req, 1);
      check_val("t2_if_addr", o_mem_addr, 32'h104);
      i_mem_ready = 1; i_mem_rdata = 32'h55667788;
      tick();
      check_val("t2_if_ack", o_if_ack, 1);
      idle_inputs();
      tick();

      // D held continuously with IF pending: IF gets in within DATA_RUN D grants
      i_if_req = 1; i_if_addr = 32'h300;
      i_d_req = 1; i_d_addr = 32'h5000; i_d_r_w = 1; i_d_size = 2;
      dcount = 0; first_if = -1; if_seen = 0; prev_req = 0;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (o_mem_req && !prev_req) begin
            if (o_mem_addr == 32'h300) begin
               if (!if_seen) first_if = dcount;
               if_seen = 1;
            end else dcount++;
         end
         prev_req = o_mem_req;
         i_mem_ready = o_mem_req; i_mem_rdata = $urandom;
         if (o_d_ack) i_d_addr = i_d_addr + 4;
         if (o_if_ack) i_if_req = 0;
         if (if_seen && dcount >= first_if + 2) break;
      end
      check_val("fair_if_seen", if_seen, 1);
      check_val("fair_d_first", first_if >= 1, 1);
      check_val("fair_bound", first_if <= DR, 1);
      check_val("fair_d_resume", dcount >= first_if + 2, 1);
      idle_inputs();
      repeat (3) begin
         tick();
         i_mem_ready = o_mem_req;
      end
      i_mem_ready = 0;
      tick();

      // misaligned half store: error ack next cycle, memory untouched
      i_d_req = 1; i_d_addr = 32'h2001; i_d_r_w = 0; i_d_size = 1; i_d_wdata = 32'hABCD;
      tick();
      check_val("t4_d_ack", o_d_ack, 1);
      check_val("t4_d_err", o_d_err, 1);
      check_val("t4_rdata", o_d_rdata, 0);
      check_val("t4_mem_req", o_mem_req, 0);
      i_d_req = 0;
      tick();
      check_val("t4_mem_req2", o_mem_req, 0);

      // timeout: memory never answers
      i_d_req = 1; i_d_addr = 32'h3000; i_d_r_w = 1; i_d_size = 2;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (o_d_ack) break;
         if (o_mem_req) n++;
      end
      check_val("t5_req_cycles", n, TO);
      check_val("t5_ack", o_d_ack, 1);
      check_val("t5_err", o_d_err, 1);
      check_val("t5_rdata", o_d_rdata, 0);
      i_d_req = 0;
      tick();

      // mem_ready on the same edge as the timeout wins
      i_d_req = 1; i_d_addr = 32'h3004;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (o_d_ack) break;
         if (o_mem_req) n++;
         if (n == TO) begin
            i_mem_ready = 1; i_mem_rdata = 32'hCAFE0000;
         end
      end
      check_val("t5b_ack", o_d_ack, 1);
      check_val("t5b_err", o_d_err, 0);
      check_val("t5b_rdata", o_d_rdata, 32'hCAFE0000);
      idle_inputs();
      tick();

      // reset during D access abandons it; a later fetch completes
      i_d_req = 1; i_d_addr = 32'h4000;
      tick();
      tick();
      i_reset = 1;
      tick();
      check_val("t6_mem_req", o_mem_req, 0);
      check_val("t6_no_ack", o_d_ack, 0);
      i_reset = 0; i_d_req = 0;
      tick();
      check_val("t6_no_ack2", o_d_ack, 0);
      i_if_req = 1; i_if_addr = 32'h200;
      tick();
      check_val("t6_if_gnt", o_mem_req, 1);
      i_mem_ready = 1; i_mem_rdata = 32'h0badf00d;
      tick();
      check_val("t6_if_ack", o_if_ack, 1);
      check_val("t6_if_rdata", o_if_rdata, 32'h0badf00d);
      idle_inputs();
      tick();

      // randomized traffic
      armed = 0; mem_cnt = 0; mem_dly = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         i_reset = ($urandom % 400 == 0);
         if (i_if_req) begin
            if (o_if_ack) begin
               if ($urandom % 2 == 0) new_if(); else i_if_req = 0;
            end
         end else if ($urandom % 3 == 0) new_if();
         if (i_d_req) begin
            if (o_d_ack) begin
               if ($urandom % 2 == 0) new_d(); else i_d_req = 0;
            end
         end else if ($urandom % 2 == 0) new_d();
         i_mem_rdata = $urandom;
         if (o_mem_req) begin
            if (!armed) begin
               armed = 1; mem_cnt = 0; mem_dly = $urandom_range(0, 9);
            end
            i_mem_ready = (mem_cnt == mem_dly);
            mem_cnt++;
         end else begin
            armed = 0;
            i_mem_ready = ($urandom % 4 == 0);
         end
      end
      i_reset = 0;
      idle_inputs();
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
